victim_cache: RTL and testbench

Small fully-associative victim buffer between the L1 cache controller and the L2/memory path. It captures lines evicted by L1, answers L1 miss lookups with a single-cycle hit/miss decision, and returns hit lines to L1 as a swap. It forwards dirty lines displaced from the buffer to memory through a one-entry writeback buffer with a valid/ready handshake.

---
 rtl/victim_cache_pkg.sv | 34 +++
 rtl/victim_cache_match_encoder.sv | 35 +++
 rtl/victim_cache.sv | 163 ++++++++++++++++
 tb/tb_victim_cache.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/victim_cache_pkg.sv
// Shared cache definitions: line/entry structs, victim-cache FSM states and address helpers.
package cache_def;

  localparam int ADDR_W             = 32;
  localparam int LINE_W             = 128;
  localparam int OFFSET_W           = 4;
  localparam int TAG_W              = ADDR_W - OFFSET_W;
  localparam int VC_ENTRIES_DEFAULT = 4;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } evict_data_type;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } vc_entry_type;

  typedef enum logic {
    VC_IDLE = 1'b0,
    VC_SWAP = 1'b1
  } vc_state_type;

  // Stored tags drop the line offset; outgoing addresses put it back as zero.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag);
    return {tag, {OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/victim_cache_match_encoder.sv
// Combinational tag compare across all victim entries: hit flag/index and lowest free index.
module vc_match_encoder
  import cache_def::*;
#(
  parameter int N = VC_ENTRIES_DEFAULT
) (
  input  vc_entry_type           entries_i [N],
  input  logic [TAG_W-1:0]       tag_i,
  output logic                   hit_o,
  output logic [$clog2(N)-1:0]   hit_idx_o,
  output logic                   free_o,
  output logic [$clog2(N)-1:0]   free_idx_o
);

  always_comb begin
    // NOTE: every output gets a default before the loop, otherwise a path with no
    // match would hold the previous value and synthesis would infer a latch.
    hit_o      = 1'b0;
    hit_idx_o  = '0;
    free_o     = 1'b0;
    free_idx_o = '0;
    // Scan downwards so the lowest matching/free index is the one left standing.
    for (int i = N - 1; i >= 0; i--) begin
      if (entries_i[i].valid && (entries_i[i].tag == tag_i)) begin
        hit_o     = 1'b1;
        hit_idx_o = ($clog2(N))'(i);
      end
      if (!entries_i[i].valid) begin
        free_o     = 1'b1;
        free_idx_o = ($clog2(N))'(i);
      end
    end
  end

endmodule

// File: rtl/victim_cache.sv
// Fully-associative victim buffer with swap-on-hit and a one-entry dirty writeback buffer.
// Optional hit/miss counters are built when VICTIM_CACHE_STATS_EN is defined.
module victim_cache
  import cache_def::*;
#(
  parameter int VC_ENTRIES = VC_ENTRIES_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                lookup_valid_i,
  input  logic [ADDR_W-1:0]   lookup_addr_i,
  output logic                vc_miss_o,
  output evict_data_type      swap_o,
  input  evict_data_type      evict_i,
  output logic                busy_o,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [ADDR_W-1:0]   wb_addr_o,
  output logic [LINE_W-1:0]   wb_data_o,
  output logic [31:0]         no_vc_hit_o,
  output logic [31:0]         no_vc_miss_o
);

  localparam int RR_W = $clog2(VC_ENTRIES);

  vc_entry_type   entries_q [VC_ENTRIES];
  vc_entry_type   entries_d [VC_ENTRIES];
  vc_entry_type   wb_q, wb_d;
  evict_data_type swap_q, swap_d;
  vc_state_type   state_q, state_d;
  logic [RR_W-1:0] rr_q, rr_d;

  logic [TAG_W-1:0] lookup_tag, insert_tag;
  logic             lk_hit, ins_hit, free_found, ins_free_unused;
  logic [RR_W-1:0]  lk_idx, ins_idx, free_idx, ins_free_idx_unused;
  logic             lookup_active, entry_hit, wb_hit, wb_drain, insert_en;
  vc_entry_type     new_entry;

  assign lookup_tag = lookup_addr_i[ADDR_W-1:OFFSET_W];
  assign insert_tag = evict_i.addr[ADDR_W-1:OFFSET_W];

  vc_match_encoder #(.N(VC_ENTRIES)) u_lookup_match (
    .entries_i  (entries_q),
    .tag_i      (lookup_tag),
    .hit_o      (lk_hit),
    .hit_idx_o  (lk_idx),
    .free_o     (free_found),
    .free_idx_o (free_idx)
  );

  vc_match_encoder #(.N(VC_ENTRIES)) u_insert_match (
    .entries_i  (entries_q),
    .tag_i      (insert_tag),
    .hit_o      (ins_hit),
    .hit_idx_o  (ins_idx),
    .free_o     (ins_free_unused),
    .free_idx_o (ins_free_idx_unused)
  );

  assign lookup_active = lookup_valid_i && (state_q == VC_IDLE);
  assign entry_hit     = lookup_active && lk_hit;
  // The writeback buffer is only consulted when no entry matches.
  assign wb_hit        = lookup_active && !lk_hit && wb_q.valid && (wb_q.tag == lookup_tag);
  assign vc_miss_o     = lookup_active && !lk_hit && !wb_hit;
  assign wb_drain      = wb_q.valid && wb_ready_i;
  assign busy_o        = wb_q.valid && !free_found && entries_q[rr_q].dirty && !wb_ready_i;
  assign insert_en     = evict_i.valid && !busy_o;

  assign new_entry = '{valid: 1'b1, dirty: evict_i.dirty, tag: insert_tag, data: evict_i.data};

  always_comb begin
    entries_d = entries_q;
    wb_d      = wb_q;
    swap_d    = '0;
    state_d   = VC_IDLE;
    rr_d      = rr_q;

    if (wb_drain) wb_d.valid = 1'b0;

    if (entry_hit) begin
      swap_d = '{valid: 1'b1, dirty: entries_q[lk_idx].dirty,
                 addr: line_addr(entries_q[lk_idx].tag), data: entries_q[lk_idx].data};
      entries_d[lk_idx].valid = 1'b0;
      entries_d[lk_idx].dirty = 1'b0;
      state_d = VC_SWAP;
    end else if (wb_hit) begin
      swap_d = '{valid: 1'b1, dirty: 1'b1, addr: line_addr(wb_q.tag), data: wb_q.data};
      wb_d.valid = 1'b0;
      state_d = VC_SWAP;
    end

    // Insert is applied after the hit clear, so a same-edge hit on the same
    // entry returns the old line and the entry then holds the new one.
    if (insert_en) begin
      if (ins_hit) begin
        entries_d[ins_idx]       = new_entry;
        entries_d[ins_idx].dirty = entries_q[ins_idx].dirty | evict_i.dirty;
      end else if (free_found) begin
        entries_d[free_idx] = new_entry;
      end else begin
        if (entries_q[rr_q].dirty) wb_d = entries_q[rr_q];
        entries_d[rr_q] = new_entry;
        rr_d = rr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= VC_IDLE;
      rr_q    <= '0;
      swap_q  <= '0;
      wb_q    <= '0;
      // NOTE: the whole entry array is reset, not just valid/dirty; it is only a
      // handful of lines and it keeps swap/writeback data free of X after reset.
      for (int i = 0; i < VC_ENTRIES; i++) entries_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the values
      // computed from the previous state, independent of statement order.
      state_q   <= state_d;
      rr_q      <= rr_d;
      swap_q    <= swap_d;
      wb_q      <= wb_d;
      entries_q <= entries_d;
    end
  end

  assign swap_o     = swap_q;
  assign wb_valid_o = wb_q.valid;
  assign wb_addr_o  = line_addr(wb_q.tag);
  assign wb_data_o  = wb_q.data;

`ifdef VICTIM_CACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q + {31'd0, (entry_hit || wb_hit)};
    miss_cnt_d = miss_cnt_q + {31'd0, vc_miss_o};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign no_vc_hit_o  = hit_cnt_q;
  assign no_vc_miss_o = miss_cnt_q;
`else
  assign no_vc_hit_o  = '0;
  assign no_vc_miss_o = '0;
`endif

  // Line-offset bits and the always-set writeback dirty flag carry no information.
  logic unused_bits;
  assign unused_bits = ^{lookup_addr_i[OFFSET_W-1:0], evict_i.addr[OFFSET_W-1:0], wb_q.dirty,
                         ins_free_unused, ins_free_idx_unused};

endmodule

// File: tb/tb_victim_cache.sv
// Scoreboard bench for victim_cache: expected swaps/writebacks are queued at stimulus time
// and popped by a negedge monitor; reset, busy, writeback-hit and stats paths are covered.
module tb_victim_cache;
  import cache_def::*;

`ifdef VICTIM_CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_i = 1'b1;
  logic              lookup_valid_i;
  logic [ADDR_W-1:0] lookup_addr_i;
  logic              vc_miss_o;
  evict_data_type    swap_o;
  evict_data_type    evict_i;
  logic              busy_o;
  logic              wb_valid_o;
  logic              wb_ready_i;
  logic [ADDR_W-1:0] wb_addr_o;
  logic [LINE_W-1:0] wb_data_o;
  logic [31:0]       no_vc_hit_o;
  logic [31:0]       no_vc_miss_o;

  victim_cache #(.VC_ENTRIES(4)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .lookup_valid_i (lookup_valid_i),
    .lookup_addr_i  (lookup_addr_i),
    .vc_miss_o      (vc_miss_o),
    .swap_o         (swap_o),
    .evict_i        (evict_i),
    .busy_o         (busy_o),
    .wb_valid_o     (wb_valid_o),
    .wb_ready_i     (wb_ready_i),
    .wb_addr_o      (wb_addr_o),
    .wb_data_o      (wb_data_o),
    .no_vc_hit_o    (no_vc_hit_o),
    .no_vc_miss_o   (no_vc_miss_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int exp_hits = 0;
  int exp_misses = 0;

  evict_data_type     swap_exp_q[$];
  logic [ADDR_W+LINE_W-1:0] wb_exp_q[$];

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] pat(input logic [7:0] b);
    return {16{b}};
  endfunction

  function automatic evict_data_type line(input logic d, input logic [ADDR_W-1:0] a,
                                          input logic [LINE_W-1:0] dt);
    return '{valid: 1'b1, dirty: d, addr: a, data: dt};
  endfunction

  // Output monitor, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (!rst_i) begin
      if (swap_o.valid) begin
        if (swap_exp_q.size() == 0) check("swap_unexpected", swap_o.valid, 1'b0);
        else check("swap_line", swap_o, swap_exp_q.pop_front());
      end
      if (wb_valid_o && wb_ready_i) begin
        if (wb_exp_q.size() == 0) check("wb_unexpected", wb_valid_o, 1'b0);
        else check("wb_line", {wb_addr_o, wb_data_o}, wb_exp_q.pop_front());
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_insert(input logic d, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] dt);
    evict_i = line(d, a, dt);
    cyc();
    evict_i = '0;
  endtask

  task automatic do_lookup_miss(input logic [ADDR_W-1:0] a);
    lookup_valid_i = 1'b1;
    lookup_addr_i  = a;
    #1;
    check("lookup_miss", vc_miss_o, 1'b1);
    cyc();
    lookup_valid_i = 1'b0;
    exp_misses++;
  endtask

  // Drives a hitting lookup; returns right after the hit edge (DUT now in SWAP).
  task automatic do_lookup_hit(input logic [ADDR_W-1:0] a, input evict_data_type exp_line,
                               input bit expect_swap);
    lookup_valid_i = 1'b1;
    lookup_addr_i  = a;
    #1;
    check("lookup_hit", vc_miss_o, 1'b0);
    if (expect_swap) swap_exp_q.push_back(exp_line);
    cyc();
    lookup_valid_i = 1'b0;
    exp_hits++;
  endtask

  task automatic check_stats(input string tag);
    check({tag, "_hits"},   no_vc_hit_o,  STATS ? 32'(exp_hits)   : 32'd0);
    check({tag, "_misses"}, no_vc_miss_o, STATS ? 32'(exp_misses) : 32'd0);
  endtask

  initial begin
    lookup_valid_i = 1'b0;
    lookup_addr_i  = '0;
    evict_i        = '0;
    wb_ready_i     = 1'b0;
    repeat (2) cyc();
    check("rst_swap",     swap_o, '0);
    check("rst_wb_valid", wb_valid_o, 1'b0);
    check("rst_wb_addr",  wb_addr_o, '0);
    check("rst_busy",     busy_o, 1'b0);
    rst_i = 1'b0;
    cyc();

    // Empty buffer: first lookup misses combinationally.
    do_lookup_miss(32'h0000_1000);
    check("idle_busy", busy_o, 1'b0);
    check("idle_wb_valid", wb_valid_o, 1'b0);

    // Clean insert, hit on a different offset, entry freed by the swap.
    do_insert(1'b0, 32'h0000_1000, pat(8'hA5));
    do_lookup_hit(32'h0000_1004, line(1'b0, 32'h0000_1000, pat(8'hA5)), 1'b1);
    cyc();
    do_lookup_miss(32'h0000_1000);

    // Fill all four, then force out the dirty entry at rr=0 into the writeback buffer.
    do_insert(1'b1, 32'h0000_2000, pat(8'h20));
    do_insert(1'b0, 32'h0000_3000, pat(8'h30));
    do_insert(1'b0, 32'h0000_4000, pat(8'h40));
    do_insert(1'b0, 32'h0000_5000, pat(8'h50));
    do_insert(1'b0, 32'h0000_6000, pat(8'h60));
    check("wb_fill_valid", wb_valid_o, 1'b1);
    check("wb_fill_addr",  wb_addr_o, 32'h0000_2000);
    check("wb_fill_busy",  busy_o, 1'b0);
    repeat (3) cyc();
    check("wb_hold_addr", wb_addr_o, 32'h0000_2000);
    check("wb_hold_data", wb_data_o, pat(8'h20));
    wb_ready_i = 1'b1;
    wb_exp_q.push_back({32'h0000_2000, pat(8'h20)});
    cyc();
    wb_ready_i = 1'b0;
    check("wb_drained", wb_valid_o, 1'b0);

    // In-place dirty merge, then replacement pushes 0x3000 to writeback; lookup reclaims it.
    do_insert(1'b1, 32'h0000_3000, pat(8'h31));
    do_insert(1'b1, 32'h0000_7000, pat(8'h70));
    check("wb2_addr", wb_addr_o, 32'h0000_3000);
    do_lookup_hit(32'h0000_3008, line(1'b1, 32'h0000_3000, pat(8'h31)), 1'b1);
    check("wb_hit_cleared", wb_valid_o, 1'b0);
    cyc();
    do_lookup_miss(32'h0000_3000);

    // Build the busy condition: wb full, all valid, rr entry dirty, memory stalled.
    do_insert(1'b1, 32'h0000_4000, pat(8'h41));
    do_insert(1'b0, 32'h0000_8000, pat(8'h80));
    check("wb3_addr", wb_addr_o, 32'h0000_4000);
    check("pre_busy", busy_o, 1'b0);
    do_insert(1'b1, 32'h0000_5000, pat(8'h51));
    check("busy_set", busy_o, 1'b1);
    do_insert(1'b0, 32'h0000_9000, pat(8'h90));
    check("busy_drop_wb", wb_addr_o, 32'h0000_4000);
    do_lookup_miss(32'h0000_9000);
    wb_ready_i = 1'b1;
    #1;
    check("busy_release", busy_o, 1'b0);
    wb_exp_q.push_back({32'h0000_4000, pat(8'h41)});
    do_insert(1'b0, 32'h0000_9000, pat(8'h90));
    wb_ready_i = 1'b0;
    check("refill_valid", wb_valid_o, 1'b1);
    check("refill_addr",  wb_addr_o, 32'h0000_5000);
    check("refill_data",  wb_data_o, pat(8'h51));
    wb_ready_i = 1'b1;
    wb_exp_q.push_back({32'h0000_5000, pat(8'h51)});
    cyc();
    wb_ready_i = 1'b0;
    check("refill_drained", wb_valid_o, 1'b0);

    // Hits; during SWAP a lookup is ignored and an insert lands in the freed entry.
    do_lookup_hit(32'h0000_6000, line(1'b0, 32'h0000_6000, pat(8'h60)), 1'b1);
    lookup_valid_i = 1'b1;
    lookup_addr_i  = 32'h0000_F000;
    evict_i        = line(1'b1, 32'h0000_A000, pat(8'hA0));
    #1;
    check("swap_no_miss", vc_miss_o, 1'b0);
    cyc();
    lookup_valid_i = 1'b0;
    evict_i        = '0;
    do_lookup_hit(32'h0000_A004, line(1'b1, 32'h0000_A000, pat(8'hA0)), 1'b1);
    cyc();
    do_lookup_hit(32'h0000_8000, line(1'b0, 32'h0000_8000, pat(8'h80)), 1'b1);
    cyc();
    do_lookup_hit(32'h0000_700C, line(1'b1, 32'h0000_7000, pat(8'h70)), 1'b1);
    cyc();
    check_stats("stats");

    // Reset in the middle of a SWAP cycle.
    do_lookup_hit(32'h0000_9000, line(1'b0, 32'h0000_9000, pat(8'h90)), 1'b0);
    rst_i = 1'b1;
    #1;
    exp_hits   = 0;
    exp_misses = 0;
    check("midswap_rst_swap", swap_o, '0);
    check("midswap_rst_wb",   wb_valid_o, 1'b0);
    check("midswap_rst_busy", busy_o, 1'b0);
    check_stats("rst");
    cyc();
    rst_i = 1'b0;
    cyc();
    do_lookup_miss(32'h0000_9000);
    check_stats("post_rst");

    check("swap_sb_empty", 32'(swap_exp_q.size()), 32'd0);
    check("wb_sb_empty",   32'(wb_exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
